riscv_regfile_mp: RTL and testbench

//   Multi-ported integer register file for the multi-cycle RISC-V core.

---
 rtl/riscv_regfile_mp_if.sv | 20 ++
 rtl/riscv_regfile_mp.sv | 74 +++++++
 tb/tb_riscv_regfile_mp.sv | 129 ++++++++++++
 3 files changed

// File: rtl/riscv_regfile_mp_if.sv
// Register-file port bundle: read/write address and data buses plus the clear-sweep Busy flag.
// The master drives addresses, enables and write data; the slave returns read data and Busy.
interface riscv_regfile_mp_if #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned REG_DEPTH = 32,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned NUM_WR    = 1
);
  localparam int unsigned AW = $clog2(REG_DEPTH);

  logic [NUM_RD*AW-1:0]        Rd_addr;
  logic [NUM_RD*REG_WIDTH-1:0] Rd_data;
  logic [NUM_WR-1:0]           Wr_en;
  logic [NUM_WR*AW-1:0]        Wr_addr;
  logic [NUM_WR*REG_WIDTH-1:0] Wr_data;
  logic                        Busy;

  modport master (output Rd_addr, Wr_en, Wr_addr, Wr_data, input Rd_data, Busy);
  modport slave  (input Rd_addr, Wr_en, Wr_addr, Wr_data, output Rd_data, Busy);
endinterface

// File: rtl/riscv_regfile_mp.sv
// Multi-ported integer register file: registered reads, x0 hardwired to zero, post-reset clear sweep.
// Optional macro REGFILE_FWD_EN enables same-cycle write-to-read forwarding.
module riscv_regfile_mp #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned REG_DEPTH = 32,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned NUM_WR    = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  riscv_regfile_mp_if.slave bus
);
  localparam int unsigned AW = $clog2(REG_DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                      r_state;
  logic [AW-1:0]               r_cnt;
  logic                        r_busy;
  logic [REG_WIDTH-1:0]        r_mem [REG_DEPTH];
  logic [NUM_RD*REG_WIDTH-1:0] r_rd_data;
  logic [NUM_RD*REG_WIDTH-1:0] w_rd_nxt;

  assign bus.Rd_data = r_rd_data;
  assign bus.Busy    = r_busy;

  // Next read data per port; later write ports override earlier ones so the highest index wins.
  always_comb begin
    w_rd_nxt = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      if (bus.Rd_addr[p*AW +: AW] != '0) begin
        w_rd_nxt[p*REG_WIDTH +: REG_WIDTH] = r_mem[bus.Rd_addr[p*AW +: AW]];
`ifdef REGFILE_FWD_EN
        for (int w = 0; w < int'(NUM_WR); w++) begin
          if (bus.Wr_en[w] && (bus.Wr_addr[w*AW +: AW] == bus.Rd_addr[p*AW +: AW])) begin
            w_rd_nxt[p*REG_WIDTH +: REG_WIDTH] = bus.Wr_data[w*REG_WIDTH +: REG_WIDTH];
          end
        end
`endif
      end
    end
  end

  // Clear sweep starts at entry 1 (x0 is never stored), then normal read/write operation.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_CLEAR;
      r_cnt     <= AW'(1);
      r_busy    <= 1'b1;
      r_rd_data <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_mem[r_cnt] <= '0;
          r_cnt        <= r_cnt + AW'(1);
          r_rd_data    <= '0;
          if (r_cnt == AW'(REG_DEPTH - 1)) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_rd_data <= w_rd_nxt;
          for (int w = 0; w < int'(NUM_WR); w++) begin
            if (bus.Wr_en[w] && (bus.Wr_addr[w*AW +: AW] != '0)) begin
              r_mem[bus.Wr_addr[w*AW +: AW]] <= bus.Wr_data[w*REG_WIDTH +: REG_WIDTH];
            end
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Scoreboard bench for riscv_regfile_mp (2 read, 2 write ports); follows REGFILE_FWD_EN when defined.
module tb_riscv_regfile_mp;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;
`ifdef REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  riscv_regfile_mp_if #(.REG_WIDTH(W), .REG_DEPTH(D), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  riscv_regfile_mp #(.REG_WIDTH(W), .REG_DEPTH(D), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: each clock edge presents one set of outputs, matched against the oldest expectation.
  exp_t m;
  always @(posedge Clk) begin
    #1;
    if (q.size() != 0) begin
      m = q.pop_front();
      cmp({m.nm, ".rd0"}, bus.Rd_data[31:0], m.e0);
      cmp({m.nm, ".rd1"}, bus.Rd_data[63:32], m.e1);
      cmp({m.nm, ".busy"}, 32'(bus.Busy), 32'(m.eb));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string nm, input bit rst, input int wen,
                      input int wa0, input logic [31:0] wd0,
                      input int wa1, input logic [31:0] wd1,
                      input int ra0, input int ra1,
                      input logic [31:0] e0, input logic [31:0] e1, input bit eb);
    exp_t e;
    Rst         = rst;
    bus.Wr_en   = 2'(wen);
    bus.Wr_addr = {5'(wa1), 5'(wa0)};
    bus.Wr_data = {wd1, wd0};
    bus.Rd_addr = {5'(ra1), 5'(ra0)};
    e.nm = nm; e.e0 = e0; e.e1 = e1; e.eb = eb;
    q.push_back(e);
    @(negedge Clk);
  endtask

  initial begin
    // Reset, then the sweep: Busy high for 31 sampled cycles, reads return 0 throughout.
    step("rst", 1, 0, 0, 0, 0, 0, 3, 4, 0, 0, 1);
    for (int k = 0; k < 31; k++)
      step("sweep", 0, 0, 0, 0, 0, 0, k, 31 - k, 0, 0, k < 30);
    for (int i = 0; i < 32; i++)
      step("zero", 0, 0, 0, 0, 0, 0, i, 31 - i, 0, 0, 0);

    step("wr5", 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    step("rd5", 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0);

    step("wr0", 0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    step("rd0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("wr0p1", 0, 2, 0, 0, 0, 32'h5A5A5A5A, 0, 0, 0, 0, 0);
    step("rd0b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step("wr7", 0, 1, 7, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    step("rw7", 0, 1, 7, 32'h22, 0, 0, 7, 7,
         FWD ? 32'h22 : 32'h11, FWD ? 32'h22 : 32'h11, 0);
    step("rd7", 0, 0, 0, 0, 0, 0, 7, 0, 32'h22, 0, 0);

    step("col3", 0, 3, 3, 32'hAA, 3, 32'hBB, 0, 0, 0, 0, 0);
    step("rd3", 0, 0, 0, 0, 0, 0, 3, 3, 32'hBB, 32'hBB, 0);
    step("colfw9", 0, 3, 9, 32'hAA, 9, 32'hBB, 9, 9,
         FWD ? 32'hBB : 32'h0, FWD ? 32'hBB : 32'h0, 0);
    step("rd9", 0, 0, 0, 0, 0, 0, 9, 0, 32'hBB, 0, 0);

    step("wr1011", 0, 3, 10, 32'h100, 11, 32'h200, 0, 0, 0, 0, 0);
    step("rd1011", 0, 0, 0, 0, 0, 0, 11, 10, 32'h200, 32'h100, 0);
    step("nowr12", 0, 0, 12, 32'hFFFF, 12, 32'hEEEE, 0, 0, 0, 0, 0);
    step("rd12", 0, 0, 0, 0, 0, 0, 12, 12, 0, 0, 0);
    step("rd5b", 0, 0, 0, 0, 0, 0, 5, 3, 32'hDEADBEEF, 32'hBB, 0);

    // Second reset, interrupted at sweep count 10, then a full fresh sweep with ignored writes.
    step("rst2", 1, 0, 0, 0, 0, 0, 5, 7, 0, 0, 1);
    for (int k = 0; k < 9; k++)
      step("sweep9", 0, 0, 0, 0, 0, 0, 5, 7, 0, 0, 1);
    step("rstmid", 1, 0, 0, 0, 0, 0, 5, 7, 0, 0, 1);
    for (int k = 0; k < 31; k++)
      step("sweep2", 0, (k == 20) ? 1 : ((k == 25) ? 2 : 0),
           5, 32'hCAFE, 20, 32'hBEEF, 5, 20, 0, 0, k < 30);
    step("lost", 0, 0, 0, 0, 0, 0, 5, 20, 0, 0, 0);
    step("clr", 0, 0, 0, 0, 0, 0, 7, 3, 0, 0, 0);
    step("clr2", 0, 0, 0, 0, 0, 0, 9, 11, 0, 0, 0);

    bus.Wr_en = '0;
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge Clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
